// File: rtl/sprite_fetch_arbiter_if.sv
// CPU-side and RAM-side signals of the sprite fetch arbiter.
// slave is the arbiter view; master is the CPU/RAM view.
interface sprite_fetch_arbiter_if #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int DATA_WIDTH    = 32
);
    logic                     cpu_req;
    logic                     cpu_wEn;
    logic [ADDRESS_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0]    cpu_dataIn;
    logic                     cpu_ack;
    logic [DATA_WIDTH-1:0]    cpu_rdata;
    logic                     cpu_rdata_valid;
    logic                     ram_wEn;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]    ram_dataIn;
    logic [DATA_WIDTH-1:0]    ram_dataOut;

    modport slave (
        input  cpu_req, cpu_wEn, cpu_addr, cpu_dataIn,
        input  ram_dataOut,
        output cpu_ack, cpu_rdata, cpu_rdata_valid,
        output ram_wEn, ram_addr, ram_dataIn
    );

    modport master (
        output cpu_req, cpu_wEn, cpu_addr, cpu_dataIn,
        output ram_dataOut,
        input  cpu_ack, cpu_rdata, cpu_rdata_valid,
        input  ram_wEn, ram_addr, ram_dataIn
    );
endinterface

// File: rtl/sprite_fetch_arbiter.sv
// Shares one RAM port between the CPU and a per-frame sprite table fetch.
// The renderer sees a double-buffered table that only changes on commit.
module sprite_fetch_arbiter #(
    parameter int NUM_SPRITES   = 10,
    parameter int BASE_ADDR     = 1010,
    parameter int STRIDE        = 10,
    parameter int COORD_WIDTH   = 10,
    parameter int ADDRESS_WIDTH = 12,
    parameter int DATA_WIDTH    = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_start,
    sprite_fetch_arbiter_if.slave bus,
    output logic [NUM_SPRITES*COORD_WIDTH-1:0] spriteX_bus,
    output logic [NUM_SPRITES*COORD_WIDTH-1:0] spriteY_bus,
    output logic table_valid,
    output logic frame_done,
    output logic frame_overrun
);
    localparam int LAST = 2*NUM_SPRITES - 1;
    localparam int IW   = $clog2(2*NUM_SPRITES);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        COMMIT
    } state_t;

    state_t state;
    logic [IW-1:0] idx;
    logic [IW-1:0] cap_idx;
    logic cap_valid;
    logic [ADDRESS_WIDTH-1:0] fetch_addr;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [NUM_SPRITES*COORD_WIDTH-1:0] work_x;
    logic [NUM_SPRITES*COORD_WIDTH-1:0] work_y;
    logic [COORD_WIDTH-1:0] cap_word;
    logic grant;
    logic fetching;

    // Fetch wins the tie with the CPU in the frame_start cycle.
    always_comb begin
        fetching = (state == FETCH);
        grant    = 1'b0;
        unique case (1'b1)
            (state == IDLE):   grant = bus.cpu_req & ~frame_start;
            (state == DRAIN):  grant = bus.cpu_req;
            (state == COMMIT): grant = bus.cpu_req;
            default:           grant = 1'b0;
        endcase
    end

    always_comb begin
        bus.ram_addr = addr_q;
        if (fetching)
            bus.ram_addr = fetch_addr;
        else if (grant)
            bus.ram_addr = bus.cpu_addr;
    end

    assign bus.cpu_ack    = grant;
    assign bus.ram_wEn    = grant & bus.cpu_wEn;
    assign bus.ram_dataIn = bus.cpu_dataIn;
    assign bus.cpu_rdata  = bus.ram_dataOut;
    assign cap_word       = bus.ram_dataOut[COORD_WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            idx                 <= '0;
            cap_idx             <= '0;
            cap_valid           <= 1'b0;
            fetch_addr          <= ADDRESS_WIDTH'(BASE_ADDR);
            addr_q              <= '0;
            work_x              <= '0;
            work_y              <= '0;
            spriteX_bus         <= '0;
            spriteY_bus         <= '0;
            table_valid         <= 1'b0;
            frame_done          <= 1'b0;
            frame_overrun       <= 1'b0;
            bus.cpu_rdata_valid <= 1'b0;
        end else begin
            frame_done          <= 1'b0;
            bus.cpu_rdata_valid <= grant & ~bus.cpu_wEn;
            addr_q              <= bus.ram_addr;
            cap_valid           <= fetching;
            cap_idx             <= idx;

            // RAM data for the word issued last cycle is on dataOut now.
            if (cap_valid) begin
                if (cap_idx[0])
                    work_y[cap_idx[IW-1:1]*COORD_WIDTH +: COORD_WIDTH] <= cap_word;
                else
                    work_x[cap_idx[IW-1:1]*COORD_WIDTH +: COORD_WIDTH] <= cap_word;
            end

            if (frame_start && state != IDLE)
                frame_overrun <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        state      <= FETCH;
                        idx        <= '0;
                        fetch_addr <= ADDRESS_WIDTH'(BASE_ADDR);
                    end
                end
                FETCH: begin
                    if (idx == IW'(LAST)) begin
                        state <= DRAIN;
                    end else begin
                        idx <= idx + 1'b1;
                        if (idx[0])
                            fetch_addr <= fetch_addr + ADDRESS_WIDTH'(STRIDE - 1);
                        else
                            fetch_addr <= fetch_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    state <= COMMIT;
                end
                COMMIT: begin
                    spriteX_bus <= work_x;
                    spriteY_bus <= work_y;
                    frame_done  <= 1'b1;
                    table_valid <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Scoreboard bench for sprite_fetch_arbiter with a registered RAM model.
// Directed vectors push expectations; a negedge monitor pops and compares.
module tb_sprite_fetch_arbiter;
    localparam int N  = 10;
    localparam int CW = 10;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam logic [DW-1:0] RD2000 = 32'h1234_5678;

    typedef struct {
        logic [N*CW-1:0] x;
        logic [N*CW-1:0] y;
        int cyc;
    } frame_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic frame_start = 1'b0;
    logic [N*CW-1:0] sx;
    logic [N*CW-1:0] sy;
    logic tv;
    logic fd;
    logic fo;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int xv[N];
    int yv[N];
    frame_t fq[$];
    logic [DW-1:0] rq[$];
    logic [DW-1:0] mem [0:4095];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sprite_fetch_arbiter_if bus ();

    sprite_fetch_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .frame_start   (frame_start),
        .bus           (bus.slave),
        .spriteX_bus   (sx),
        .spriteY_bus   (sy),
        .table_valid   (tv),
        .frame_done    (fd),
        .frame_overrun (fo)
    );

    // Registered-read RAM; dataOut holds during write cycles.
    always @(posedge clk) begin
        if (bus.ram_wEn)
            mem[bus.ram_addr] <= bus.ram_dataIn;
        else
            bus.ram_dataOut <= mem[bus.ram_addr];
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.cpu_rdata_valid) begin
                if (rq.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL rdata_unexpected: got %0h expected none",
                             bus.cpu_rdata);
                end else begin
                    logic [DW-1:0] e;
                    e = rq.pop_front();
                    chk("rdata", bus.cpu_rdata, e);
                end
            end
            if (fd) begin
                if (fq.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL frame_done_unexpected: got 1 expected 0 at cycle %0d",
                             cyc);
                end else begin
                    frame_t f;
                    f = fq.pop_front();
                    chk("frame_x", sx, f.x);
                    chk("frame_y", sy, f.y);
                    chk("frame_cycle", cyc, f.cyc);
                    chk("frame_table_valid", tv, 1);
                end
            end
        end
    end

    task automatic cpu_write(input int a, input logic [DW-1:0] d);
        bus.cpu_req    = 1'b1;
        bus.cpu_wEn    = 1'b1;
        bus.cpu_addr   = AW'(a);
        bus.cpu_dataIn = d;
        #1;
        if (bus.cpu_ack !== 1'b1) begin
            nvec++;
            nerr++;
            $display("FAIL write_ack: got %b expected 1 addr %0d", bus.cpu_ack, a);
        end
        step();
        bus.cpu_req = 1'b0;
        bus.cpu_wEn = 1'b0;
    endtask

    task automatic cpu_read(input int a, input logic [DW-1:0] exp);
        bus.cpu_req  = 1'b1;
        bus.cpu_wEn  = 1'b0;
        bus.cpu_addr = AW'(a);
        rq.push_back(exp);
        #1;
        chk("read_ack", bus.cpu_ack, 1);
        step();
        bus.cpu_req = 1'b0;
    endtask

    task automatic load_table(input int xb, input int yb);
        for (int k = 0; k < N; k++) begin
            xv[k] = xb + k;
            yv[k] = yb + k;
            cpu_write(1010 + 10*k, DW'(xb + k));
            cpu_write(1011 + 10*k, DW'(yb + k));
        end
    endtask

    task automatic push_frame(input int s);
        frame_t f;
        for (int k = 0; k < N; k++) begin
            f.x[k*CW +: CW] = CW'(xv[k]);
            f.y[k*CW +: CW] = CW'(yv[k]);
        end
        f.cyc = s + 23;
        fq.push_back(f);
    endtask

    task automatic start_frame(input bit expect_done);
        frame_start = 1'b1;
        if (expect_done)
            push_frame(cyc);
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((fq.size() != 0 || rq.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (fq.size() != 0 || rq.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL timeout: got %0d frames %0d reads pending expected 0",
                     fq.size(), rq.size());
            fq.delete();
            rq.delete();
        end
    endtask

    task automatic run_cpu_frame(input int pre);
        bus.cpu_req  = 1'b1;
        bus.cpu_wEn  = 1'b0;
        bus.cpu_addr = AW'(2000);
        repeat (pre) begin
            #1;
            chk("pre_ack", bus.cpu_ack, 1);
            rq.push_back(RD2000);
            step();
        end
        frame_start = 1'b1;
        push_frame(cyc);
        for (int c = 0; c <= 22; c++) begin
            #1;
            chk($sformatf("ack_c%0d", c), bus.cpu_ack, (c >= 21));
            if (c >= 21)
                rq.push_back(RD2000);
            step();
            frame_start = 1'b0;
        end
        bus.cpu_req = 1'b0;
        wait_drain(40);
    endtask

    initial begin
        logic [N*CW-1:0] held;
        bus.cpu_req    = 1'b0;
        bus.cpu_wEn    = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_dataIn = '0;

        #12;
        chk("reset_table_valid", tv, 0);
        chk("reset_frame_done", fd, 0);
        chk("reset_overrun", fo, 0);
        chk("reset_rdata_valid", bus.cpu_rdata_valid, 0);
        chk("reset_sx", sx, 0);
        chk("reset_sy", sy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        load_table(100, 200);
        cpu_write(2000, RD2000);
        start_frame(1);
        wait_drain(40);
        chk("t1_table_valid", tv, 1);
        chk("t1_overrun", fo, 0);

        load_table(300, 400);
        run_cpu_frame(2);
        load_table(500, 600);
        run_cpu_frame(0);

        load_table(700, 800);
        start_frame(1);
        repeat (4) step();
        chk("t4_overrun_before", fo, 0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t4_overrun_set", fo, 1);
        wait_drain(40);
        held = sx;
        repeat (30) step();
        chk("t4_table_hold", sx, held);
        chk("t4_overrun_sticky", fo, 1);

        cpu_write(1010, 32'h000F_FFFF);
        cpu_write(1101, 32'h5A5A_A155);
        xv[0] = 32'h3FF;
        yv[9] = 32'h155;
        start_frame(1);
        repeat (20) step();
        bus.cpu_req    = 1'b1;
        bus.cpu_wEn    = 1'b1;
        bus.cpu_addr   = AW'(1011);
        bus.cpu_dataIn = 32'h3FF;
        #1;
        chk("t5_drain_write_ack", bus.cpu_ack, 1);
        step();
        bus.cpu_req = 1'b0;
        bus.cpu_wEn = 1'b0;
        wait_drain(40);
        cpu_read(1011, 32'h3FF);
        wait_drain(5);
        yv[0] = 32'h3FF;
        start_frame(1);
        wait_drain(40);

        start_frame(0);
        repeat (9) step();
        reset_n = 1'b0;
        #1;
        chk("t6_table_valid", tv, 0);
        chk("t6_sx", sx, 0);
        chk("t6_sy", sy, 0);
        chk("t6_frame_done", fd, 0);
        chk("t6_overrun", fo, 0);
        chk("t6_rdata_valid", bus.cpu_rdata_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        start_frame(1);
        wait_drain(40);
        chk("t6_table_valid_after", tv, 1);
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sprite_fetch_arbiter.md
# sprite_fetch_arbiter

Shares the single RAM port (clk, wEn, 12-bit addr, 32-bit dataIn, registered dataOut) between the CPU and a once-per-frame sprite-table fetch engine. On each frame_start the block reads the X/Y words of every enemy sprite (addresses 1010+10k / 1011+10k) into a double-buffered shadow table. The VGA renderer consumes that table, so it never sees a half-updated frame and the RAM needs no extra read ports. The block sits between the processor memory interface and the RAM instance.

## Interface
Parameters:
- NUM_SPRITES, 10, sprites fetched per frame
- BASE_ADDR, 1010, address of sprite 0 X word
- STRIDE, 10, address step between sprites
- COORD_WIDTH, 10, bits kept per coordinate (low bits of 32-bit word)
- ADDRESS_WIDTH, 12; DATA_WIDTH, 32

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at vertical blank
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_wEn  in  1  1 = write, 0 = read
- cpu_addr  in  ADDRESS_WIDTH  CPU address
- cpu_dataIn  in  DATA_WIDTH  CPU write data
- cpu_ack  out  1  combinational grant; access happens this cycle
- cpu_rdata  out  DATA_WIDTH  ram_dataOut passthrough
- cpu_rdata_valid  out  1  registered; high the cycle after a granted read
- ram_wEn / ram_addr / ram_dataIn  out  1 / ADDRESS_WIDTH / DATA_WIDTH  RAM port
- ram_dataOut  in  DATA_WIDTH  RAM registered read data
- spriteX_bus, spriteY_bus  out  NUM_SPRITES*COORD_WIDTH  shadow table, sprite k at bits [k*COORD_WIDTH +: COORD_WIDTH]
- table_valid  out  1  sticky high after first completed fetch
- frame_done  out  1  one-cycle pulse when shadow table updates
- frame_overrun  out  1  sticky; frame_start arrived while a fetch was still in progress

## Operation
- States: IDLE, FETCH, DRAIN, COMMIT.
- IDLE: on frame_start go to FETCH and clear the index. Otherwise, when cpu_req is high, grant the CPU.
- FETCH: issue read index i = 0..2N-1 (N = NUM_SPRITES).
  - addr = BASE_ADDR + STRIDE*(i>>1) + (i&1); even i is X, odd i is Y.
  - ram_wEn = 0 throughout.
  - After i = 2N-1 go to DRAIN.
- Capture: ram_dataOut is captured one cycle after each issue into a working buffer, low COORD_WIDTH bits only.
- DRAIN: capture the last word, then go to COMMIT.
- COMMIT: copy the working buffer to the shadow outputs at the end of the cycle. Pulse frame_done, set table_valid, return to IDLE.
- CPU arbitration: cpu_ack = cpu_req in IDLE (when frame_start is low), DRAIN and COMMIT. cpu_ack is 0 in FETCH and in the IDLE cycle where frame_start is high; fetch wins the tie.
- When granted, ram_* = cpu_*. When nobody is granted: ram_wEn = 0 and ram_addr = last value (don't care).
- frame_start in FETCH, DRAIN or COMMIT is ignored and sets frame_overrun.
- The shadow outputs change only at COMMIT.

## Timing
- Reset (async assert, sync release) values:
  - State IDLE, index 0.
  - All shadow and working words 0.
  - table_valid, frame_done, frame_overrun and cpu_rdata_valid all 0.
- Fetch schedule, with frame_start in IDLE at cycle 0:
  - FETCH occupies cycles 1..2N and issues index i in cycle 1+i.
  - DRAIN is cycle 2N+1; COMMIT is cycle 2N+2.
  - Shadow, frame_done and table_valid are visible in cycle 2N+3; frame_done is low again in cycle 2N+4.
  - For N=10: 23 cycles total.
- CPU stall bound: at most 2N+1 cycles (cycles 0..2N).
- CPU read latency: granted in cycle t, cpu_rdata_valid and cpu_rdata are valid in cycle t+1.
- RAM does not update dataOut on write cycles. The arbiter relies on this: a CPU write granted in DRAIN does not disturb the capture of the last fetched word.
- Reset mid-fetch: abort, shadow cleared, table_valid=0. The next frame_start restarts from index 0.

## Test plan
- Reset, then preload 1010+10k = 100+k and 1011+10k = 200+k; pulse frame_start. Required: frame_done in cycle 23, table_valid=1, sprite k X=100+k and Y=200+k.
- Hold cpu_req (read of 2000) high continuously and pulse frame_start. Required: cpu_ack low exactly in cycles 0..20 and high in cycles 21 and 22; cpu_rdata_valid follows every ack by 1 cycle.
- Set cpu_req and frame_start together in IDLE. Required: no ack in cycle 0, fetch starts, and the CPU is first acked in DRAIN.
- Pulse a second frame_start at cycle 5. Required: frame_overrun=1, exactly one frame_done, and the table is unchanged apart from the normal commit.
- Write 0x3FF to 1011 via the CPU in DRAIN, and store 0xFFFFF in 1010 before fetch. Required: sprite0 X reads 0x3FF (truncated), and the last word (1101) is captured correctly.
- Assert reset_n=0 at cycle 10 of a fetch. Required: outputs return to 0 immediately, and the next fetch completes normally.
